nco_tuner: RTL and testbench
============================

# nco_tuner

Tuning controller for the receiver front-end NCO. Accepts target frequency control words (FCW) over a valid/ready handshake and slews the live FCW toward the target in bounded steps, so tuning never produces a phase-rate discontinuity. Owns the 32-bit phase accumulator and drives the 2-bit quadrant phase consumed by `iq_modulator`. Reports busy/locked status to the channel-scan logic.

## Interface
- `FCW_W`, 32: FCW and phase accumulator width.
- `RESET_FCW`, 32'h0000_0000: FCW and target value after reset.
- `RAMP_STEP`, 32'h0010_0000: maximum FCW change per ramp step.
- `RAMP_DWELL`, 4: clock cycles per ramp step (≥1).
- `SETTLE_CYCLES`, 16: cycles held after reaching target before `locked` (≥1).

- `clk` in 1: sampling clock; all state on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: new target FCW offered.
- `req_fcw` in FCW_W: target FCW, unsigned.
- `req_ready` out 1: request can be accepted this cycle.
- `busy` out 1: state is RAMP or SETTLE.
- `locked` out 1: state is IDLE and live FCW equals target.
- `fcw` out FCW_W: live FCW, registered.
- `phase` out 2: accumulator bits [FCW_W-1:FCW_W-2], to `iq_modulator.phase`.

## Operation
- States: IDLE, RAMP, SETTLE. Reset: IDLE, `fcw`=target=RESET_FCW, acc=0, `phase`=0, `req_ready`=1, `busy`=0, `locked`=1, dwell/settle counters 0.
- Accept on `req_valid && req_ready`; latch `req_fcw` as target. `req_ready` = (state != RAMP).
- Accept in IDLE or SETTLE: if target == `fcw`, go SETTLE (settle counter cleared); else go RAMP (dwell counter cleared). Accept in SETTLE restarts settling or ramping; no request is ever dropped.
- RAMP: dwell counter counts 0..RAMP_DWELL-1; on the edge where it equals RAMP_DWELL-1, `fcw` moves toward target by min(RAMP_STEP, |target−fcw|) (unsigned compare, no wrap in FCW arithmetic) and counter clears. The step that makes `fcw` equal target also moves the state to SETTLE.
- SETTLE: settle counter counts 0..SETTLE_CYCLES-1; on the final count the state goes to IDLE.
- Accumulator: acc ← acc + `fcw` (pre-update register value) every cycle in every state, modulo 2^FCW_W; `phase` = acc top two bits, registered.
- `req_valid` ignored in RAMP; the requester holds it until ready (standard valid/ready, req_fcw stable while valid).
- `reset_n` asserted mid-ramp: all state returns to reset values immediately; the pending target is discarded.

## Timing
- Request accepted at edge N: `busy`=1, `locked`=0, `req_ready`=0 (if RAMP) from after edge N.
- Ramp of k steps: first `fcw` change at edge N+RAMP_DWELL, last at N+k·RAMP_DWELL, SETTLE from the same edge.
- IDLE, `locked`=1, `busy`=0 after edge N+k·RAMP_DWELL+SETTLE_CYCLES.
- Equal-FCW request: IDLE/locked after edge N+SETTLE_CYCLES.
- `phase` lags accumulator update by 0 cycles (same register); new `fcw` affects `phase` one edge after `fcw` changes.

## Configuration
- `NCO_TUNER_RAMP_EN` defined: stepped ramp as above.
- Undefined: RAMP lasts exactly one cycle; `fcw` loads target on the edge after acceptance and the state goes to SETTLE; RAMP_STEP and RAMP_DWELL unused, no dwell counter synthesized.

## Structure
- Package `nco_pkg`: `fcw_t` (logic [31:0]), `nco_state_e` {IDLE, RAMP, SETTLE}, quadrant typedef `quad_t` (logic [1:0]).
- Sub-module `phase_accumulator` (clk, reset_n, fcw in, phase out): accumulator register and quadrant slicing; controller FSM stays in `nco_tuner`.

## Test plan
- Reset with RESET_FCW=0: `fcw`=0, `phase`=0, `req_ready`=1, `locked`=1, `busy`=0 before first edge after reset release.
- Accept 0x0040_0000 at edge 0 (defaults, ramp enabled): `fcw` = 0x10_0000/0x20_0000/0x30_0000/0x40_0000 after edges 4/8/12/16; `locked`=1, `req_ready`=1 after edge 32.
- Downward ramp 0x0040_0000 → 0x0008_0000: steps to 0x30_0000, 0x20_0000, 0x10_0000, then 0x08_0000 (partial final step); SETTLE entered on the fourth step.
- Request equal to current `fcw`: `busy` high 16 cycles, `fcw` unchanged, `locked` after edge 16.
- Retarget in SETTLE (accept at settle count 10): new ramp begins, no lock until new target settled; `req_valid` held during RAMP is not accepted until SETTLE.
- FCW=0x4000_0000 held: `phase` sequence 1,2,3,0,1 on consecutive edges (wrap-around); `reset_n` pulsed mid-ramp returns `fcw`=RESET_FCW, `phase`=0 asynchronously.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types for the NCO tuning controller and its phase accumulator.
// The stepped FCW ramp is compiled in only when NCO_TUNER_RAMP_EN is defined.
package nco_pkg;

    typedef logic [31:0] fcw_t;
    typedef logic [1:0]  quad_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } nco_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Free-running NCO phase accumulator; the quadrant output is the top two
// bits of the accumulator register itself, so it carries no extra latency.
module phase_accumulator
    import nco_pkg::*;
#(
    parameter int unsigned FCW_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [FCW_W-1:0] fcw,
    output quad_t            phase
);

    logic [FCW_W-1:0] acc_q;
    logic [FCW_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q + fcw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign phase = acc_q[FCW_W-1 -: 2];

endmodule

// File: rtl/nco_tuner.sv
// NCO tuning controller: accepts target FCWs and slews the live FCW toward them.
// Define NCO_TUNER_RAMP_EN for the stepped ramp; otherwise the FCW jumps in one cycle.
module nco_tuner
    import nco_pkg::*;
#(
    parameter int unsigned      FCW_W         = 32,
    parameter logic [FCW_W-1:0] RESET_FCW     = '0,
    parameter logic [FCW_W-1:0] RAMP_STEP     = FCW_W'(32'h0010_0000),
    parameter int unsigned      RAMP_DWELL    = 4,
    parameter int unsigned      SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [FCW_W-1:0] req_fcw,
    output logic             req_ready,
    output logic             busy,
    output logic             locked,
    output logic [FCW_W-1:0] fcw,
    output quad_t            phase
);

    localparam int unsigned     ST_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    nco_state_e       state_q, state_d;
    logic [FCW_W-1:0] fcw_q, fcw_d;
    logic [FCW_W-1:0] target_q, target_d;
    logic [ST_W-1:0]  settle_q, settle_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             accept;

`ifdef NCO_TUNER_RAMP_EN
    localparam int unsigned     DW_W    = cnt_width(RAMP_DWELL);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(RAMP_DWELL - 1);

    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             going_up;
    logic [FCW_W-1:0] gap;
    logic [FCW_W-1:0] stride;
    logic [FCW_W-1:0] step_fcw;

    // One bounded step toward the target; the final step may be partial.
    always_comb begin
        going_up = (target_q >= fcw_q);
        gap      = going_up ? (target_q - fcw_q) : (fcw_q - target_q);
        stride   = (gap > RAMP_STEP) ? RAMP_STEP : gap;
        step_fcw = going_up ? (fcw_q + stride) : (fcw_q - stride);
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{RAMP_STEP, 32'(RAMP_DWELL)};
`endif

    always_comb begin
        state_d  = state_q;
        fcw_d    = fcw_q;
        target_d = target_q;
        settle_d = settle_q;
`ifdef NCO_TUNER_RAMP_EN
        dwell_d  = dwell_q;
`endif
        accept   = req_valid && req_ready_q;

        case (state_q)
            IDLE, SETTLE: begin
                if (state_q == SETTLE) begin
                    if (settle_q == ST_LAST) begin
                        state_d = IDLE;
                    end else begin
                        settle_d = settle_q + ST_W'(1);
                    end
                end
                // A new request overrides any settling in progress.
                if (accept) begin
                    target_d = req_fcw;
                    settle_d = '0;
`ifdef NCO_TUNER_RAMP_EN
                    dwell_d  = '0;
`endif
                    state_d  = (req_fcw == fcw_q) ? SETTLE : RAMP;
                end
            end

            RAMP: begin
`ifdef NCO_TUNER_RAMP_EN
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    fcw_d   = step_fcw;
                    if (step_fcw == target_q) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
`else
                fcw_d    = target_q;
                state_d  = SETTLE;
                settle_d = '0;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d != RAMP);
        busy_d      = (state_d != IDLE);
        locked_d    = (state_d == IDLE) && (fcw_d == target_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            fcw_q       <= RESET_FCW;
            target_q    <= RESET_FCW;
            settle_q    <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            fcw_q       <= fcw_d;
            target_q    <= target_d;
            settle_q    <= settle_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
        end
    end

`ifdef NCO_TUNER_RAMP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`endif

    // The accumulator integrates the registered FCW, so a new FCW shows up
    // in the phase one edge after it appears on the fcw output.
    phase_accumulator #(
        .FCW_W (FCW_W)
    ) u_phase_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .fcw     (fcw_q),
        .phase   (phase)
    );

    assign fcw       = fcw_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_nco_tuner.sv
// Directed bench for nco_tuner; expected timing follows whichever ramp mode
// (NCO_TUNER_RAMP_EN) the design is compiled with.
module tb_nco_tuner;
    import nco_pkg::*;

`ifdef NCO_TUNER_RAMP_EN
    localparam int STEP_EDGES = 4;    // edges from acceptance to first/only fcw change
    localparam int T_SET      = 16;   // edge at which SETTLE begins for a 4-step ramp
    localparam int T_LOCK     = 32;
    localparam logic [31:0] MID_FCW = 32'h0040_0000;
`else
    localparam int STEP_EDGES = 1;
    localparam int T_SET      = 1;
    localparam int T_LOCK     = 17;
    localparam logic [31:0] MID_FCW = 32'h0100_0000;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_fcw;
    logic        req_ready;
    logic        busy;
    logic        locked;
    logic [31:0] fcw;
    quad_t       phase;

    logic        q_req_valid;
    logic [31:0] q_req_fcw;
    logic        q_req_ready;
    logic        q_busy;
    logic        q_locked;
    logic [31:0] q_fcw;
    quad_t       q_phase;

    int n_checks;
    int n_errors;

    nco_tuner u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_fcw   (req_fcw),
        .req_ready (req_ready),
        .busy      (busy),
        .locked    (locked),
        .fcw       (fcw),
        .phase     (phase)
    );

    // Second instance resting at a quarter-turn FCW to exercise phase wrap.
    nco_tuner #(
        .RESET_FCW (32'h4000_0000)
    ) u_quad (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (q_req_valid),
        .req_fcw   (q_req_fcw),
        .req_ready (q_req_ready),
        .busy      (q_busy),
        .locked    (q_locked),
        .fcw       (q_fcw),
        .phase     (q_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input int j, input int t_ready, input int t_lock);
        check_val($sformatf("%s_busy_e%0d", tag, j), {31'b0, busy}, 32'(j < t_lock));
        check_val($sformatf("%s_lock_e%0d", tag, j), {31'b0, locked}, 32'(j >= t_lock));
        check_val($sformatf("%s_rdy_e%0d", tag, j), {31'b0, req_ready}, 32'(j >= t_ready));
    endtask

    // Four-step ramp from s0; tab holds fcw before the first step and after each step.
    task automatic ramp_run(input string tag, input logic [31:0] tgt, input logic [31:0] s0,
                            input logic [31:0] t1, input logic [31:0] t2,
                            input logic [31:0] t3, input logic [31:0] t4);
        logic [31:0] tab [5];
        int k;
        tab = '{s0, t1, t2, t3, t4};
        req_fcw   = tgt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("txn %s: accepted target %h", tag, tgt);
        check_val({tag, "_fcw_e0"}, fcw, s0);
        check_status(tag, 0, T_SET, T_LOCK);
        for (int j = 1; j <= 32; j++) begin
            tick();
`ifdef NCO_TUNER_RAMP_EN
            k = (j / 4 > 4) ? 4 : j / 4;
`else
            k = 4;
`endif
            check_val($sformatf("%s_fcw_e%0d", tag, j), fcw, tab[k]);
            check_status(tag, j, T_SET, T_LOCK);
        end
    endtask

    initial begin
        int acc_edge;
        int a_edge;
        logic hs;
        logic [31:0] exp_f;
        logic [1:0]  exp_q [5];

        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_fcw     = '0;
        q_req_valid = 1'b0;
        q_req_fcw   = '0;

        // Reset values, held in reset and just after release.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_fcw", fcw, 32'h0);
        check_val("rst_phase", {30'b0, phase}, 32'h0);
        check_val("rst_ready", {31'b0, req_ready}, 32'h1);
        check_val("rst_locked", {31'b0, locked}, 32'h1);
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("rel_fcw", fcw, 32'h0);
        check_val("rel_locked", {31'b0, locked}, 32'h1);
        check_val("rel_quad_fcw", q_fcw, 32'h4000_0000);
        check_val("rel_quad_phase", {30'b0, q_phase}, 32'h0);

        // Quarter-turn FCW: phase 1,2,3,0,1 with wrap-around.
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int j = 0; j < 5; j++) begin
            tick();
            check_val($sformatf("quad_phase_e%0d", j + 1), {30'b0, q_phase}, {30'b0, exp_q[j]});
        end
        check_val("idle_phase", {30'b0, phase}, 32'h0);

        // Upward ramp 0 -> 0x0040_0000.
        ramp_run("up", 32'h0040_0000, 32'h0, 32'h0010_0000, 32'h0020_0000,
                 32'h0030_0000, 32'h0040_0000);

        // Downward ramp with a partial final step.
        ramp_run("down", 32'h0008_0000, 32'h0040_0000, 32'h0030_0000, 32'h0020_0000,
                 32'h0010_0000, 32'h0008_0000);

        // Request equal to current fcw: settle only.
        req_fcw   = 32'h0008_0000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("txn equal: accepted target %h", req_fcw);
        for (int j = 0; j <= 18; j++) begin
            if (j > 0) tick();
            check_val($sformatf("eq_fcw_e%0d", j), fcw, 32'h0008_0000);
            check_status("eq", j, 0, 16);
        end

        // Request held during RAMP must wait until SETTLE to be accepted.
        req_fcw   = 32'h0018_0000;
        req_valid = 1'b1;
        tick();
        $display("txn held_a: accepted target %h", req_fcw);
        req_fcw  = 32'h0010_0000;
        acc_edge = -1;
        for (int j = 1; j <= 30; j++) begin
            hs = req_valid && req_ready;
            tick();
            if (hs) begin
                acc_edge  = j;
                req_valid = 1'b0;
                $display("txn held_b: accepted target %h at edge %0d", req_fcw, j);
            end
            if (j < STEP_EDGES)
                exp_f = 32'h0008_0000;
            else if (j < 2 * STEP_EDGES + 1)
                exp_f = 32'h0018_0000;
            else
                exp_f = 32'h0010_0000;
            check_val($sformatf("held_fcw_e%0d", j), fcw, exp_f);
            check_val($sformatf("held_busy_e%0d", j), {31'b0, busy},
                      32'(j < 2 * STEP_EDGES + 17));
        end
        req_valid = 1'b0;
        check_val("held_accept_edge", 32'(acc_edge), 32'(STEP_EDGES + 1));
        check_val("held_locked", {31'b0, locked}, 32'h1);

        // Retarget at settle count 10.
        req_fcw   = 32'h0020_0000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("txn retarget_a: accepted target %h", req_fcw);
        a_edge = STEP_EDGES + 11;
        for (int j = 1; j <= a_edge + STEP_EDGES + 20; j++) begin
            if (j == a_edge) begin
                req_fcw   = 32'h0030_0000;
                req_valid = 1'b1;
            end
            tick();
            if (j == a_edge) begin
                req_valid = 1'b0;
                $display("txn retarget_b: offered target %h at edge %0d", req_fcw, j);
            end
            if (j < STEP_EDGES)
                exp_f = 32'h0010_0000;
            else if (j < a_edge + STEP_EDGES)
                exp_f = 32'h0020_0000;
            else
                exp_f = 32'h0030_0000;
            check_val($sformatf("rt_fcw_e%0d", j), fcw, exp_f);
            check_val($sformatf("rt_busy_e%0d", j), {31'b0, busy},
                      32'(j < a_edge + STEP_EDGES + 16));
            check_val($sformatf("rt_lock_e%0d", j), {31'b0, locked},
                      32'(j >= a_edge + STEP_EDGES + 16));
        end

        // Asynchronous reset in the middle of a long ramp.
        req_fcw   = 32'h0100_0000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        $display("txn abort: accepted target %h", req_fcw);
        repeat (6) tick();
        check_val("abort_mid_fcw", fcw, MID_FCW);
        check_val("abort_mid_busy", {31'b0, busy}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("abort_fcw", fcw, 32'h0);
        check_val("abort_phase", {30'b0, phase}, 32'h0);
        check_val("abort_busy", {31'b0, busy}, 32'h0);
        check_val("abort_locked", {31'b0, locked}, 32'h1);
        check_val("abort_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) tick();
        check_val("post_fcw", fcw, 32'h0);
        check_val("post_busy", {31'b0, busy}, 32'h0);
        check_val("post_locked", {31'b0, locked}, 32'h1);
        check_val("post_phase", {30'b0, phase}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
